// File: rtl/key_entry_ctrl_if.sv
// key_entry_ctrl_if: operation request handshake between the key sequencer and the ALU.
interface key_entry_ctrl_if #(
  parameter int DIGITS = 4
) ();
  logic                  op_valid;
  logic                  op_ready;
  logic [4*DIGITS-1:0]   op_a;
  logic [4*DIGITS-1:0]   op_b;
  logic                  op_sub;
  modport master (output op_valid, op_a, op_b, op_sub, input op_ready);
  modport slave  (input op_valid, op_a, op_b, op_sub, output op_ready);
endinterface

// File: rtl/key_entry_ctrl.sv
// key_entry_ctrl: debounces scanner keys, edits a BCD entry and issues add/sub requests.
module key_entry_ctrl #(
  parameter int DIGITS   = 4,
  parameter int DEBOUNCE = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [4:0]                   key_value,
  input  logic                         key_intro,
  output logic [4*DIGITS-1:0]          entry,
  output logic [$clog2(DIGITS+1)-1:0]  ndigits,
  output logic [1:0]                   stage,
  output logic                         key_drop,
  key_entry_ctrl_if.master             op
);
  localparam int W  = 4*DIGITS;
  localparam int NW = $clog2(DIGITS+1);
  localparam int CW = $clog2(DEBOUNCE+1);
  localparam logic [CW-1:0] DB = CW'(DEBOUNCE);
  localparam logic [4:0] K_PLUS = 5'd16, K_MINUS = 5'd17, K_BACKS = 5'd18;
  localparam logic [4:0] K_ENTER = 5'd19, K_UP = 5'd20, K_DOWN = 5'd21;
  typedef enum logic [1:0] {WAIT_PRESS, PRESS_CNT, WAIT_RELEASE, RELEASE_CNT} db_t;
  typedef enum logic [1:0] {ENTRY_A = 2'd0, ENTRY_B = 2'd1, ISSUE = 2'd2} stage_t;
  db_t             db, db_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [4:0]      cap, cap_n;
  logic            acc, acc_n;
  stage_t          st, st_n;
  logic [W-1:0]    entry_n, a_q, a_n, b_q, b_n, stepped;
  logic [NW-1:0]   nd_n;
  logic            sub_q, sub_n, valid_q, valid_n, drop_n;
  function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic down);
    logic [W-1:0] r;
    logic         c;
    logic [3:0]   d;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (c) begin
        r[4*i +: 4] = down ? ((d == 4'd0) ? 4'd9 : d - 4'd1) : ((d == 4'd9) ? 4'd0 : d + 4'd1);
        c = down ? (d == 4'd0) : (d == 4'd9);
      end
    end
    return r;
  endfunction
  function automatic logic [NW-1:0] nsig(input logic [W-1:0] v);
    logic [NW-1:0] n;
    n = '0;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] != 4'd0) n = NW'(i + 1);
    return n;
  endfunction
  assign stepped     = bcd_step(entry, cap == K_DOWN);
  assign stage       = st;
  assign op.op_valid = valid_q;
  assign op.op_a     = a_q;
  assign op.op_b     = b_q;
  assign op.op_sub   = sub_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db  <= WAIT_PRESS;
      cnt <= '0;
      cap <= '0;
      acc <= 1'b0;
    end else begin
      db  <= db_n;
      cnt <= cnt_n;
      cap <= cap_n;
      acc <= acc_n;
    end
  end
  // accept is registered, so it rises on the edge where the count reaches DEBOUNCE
  always_comb begin
    db_n  = db;
    cnt_n = cnt;
    cap_n = cap;
    acc_n = 1'b0;
    case (db)
      WAIT_PRESS: if (key_intro) begin
        cap_n = key_value;
        cnt_n = CW'(1);
        db_n  = PRESS_CNT;
      end
      PRESS_CNT: if (!key_intro) db_n = WAIT_PRESS;
        else if (key_value != cap) begin
          cap_n = key_value;
          cnt_n = CW'(1);
        end else begin
          cnt_n = cnt + 1'b1;
          if (cnt_n == DB) begin
            acc_n = 1'b1;
            db_n  = WAIT_RELEASE;
          end
        end
      WAIT_RELEASE: if (!key_intro) begin
        cnt_n = CW'(1);
        db_n  = RELEASE_CNT;
      end
      RELEASE_CNT: if (key_intro) db_n = WAIT_RELEASE;
        else if (cnt == DB) db_n = WAIT_PRESS;
        else cnt_n = cnt + 1'b1;
      default: db_n = WAIT_PRESS;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ENTRY_A;
      entry    <= '0;
      ndigits  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      valid_q  <= 1'b0;
      key_drop <= 1'b0;
    end else begin
      st       <= st_n;
      entry    <= entry_n;
      ndigits  <= nd_n;
      a_q      <= a_n;
      b_q      <= b_n;
      sub_q    <= sub_n;
      valid_q  <= valid_n;
      key_drop <= drop_n;
    end
  end
  always_comb begin
    st_n    = st;
    entry_n = entry;
    nd_n    = ndigits;
    a_n     = a_q;
    b_n     = b_q;
    sub_n   = sub_q;
    valid_n = valid_q;
    drop_n  = 1'b0;
    if (st == ISSUE) begin
      drop_n = acc;
      if (op.op_ready) begin
        valid_n = 1'b0;
        entry_n = '0;
        nd_n    = '0;
        st_n    = ENTRY_A;
      end
    end else if (acc) begin
      if (cap <= 5'd9) begin
        if (ndigits == NW'(DIGITS)) drop_n = 1'b1;
        else if (cap != 5'd0 || ndigits != '0) begin
          entry_n = (entry << 4) | {{(W-4){1'b0}}, cap[3:0]};
          nd_n    = ndigits + 1'b1;
        end
      end else if (cap == K_BACKS) begin
        entry_n = (ndigits != '0) ? entry >> 4 : entry;
        nd_n    = (ndigits != '0) ? ndigits - 1'b1 : ndigits;
      end else if (cap == K_UP || cap == K_DOWN) begin
        entry_n = stepped;
        nd_n    = nsig(stepped);
      end else if (cap == K_PLUS || cap == K_MINUS) begin
        sub_n = (cap == K_MINUS);
        if (st == ENTRY_A) begin
          a_n     = entry;
          entry_n = '0;
          nd_n    = '0;
          st_n    = ENTRY_B;
        end
      end else if (cap == K_ENTER) begin
        if (st == ENTRY_A) drop_n = 1'b1;
        else begin
          b_n     = entry;
          valid_n = 1'b1;
          st_n    = ISSUE;
        end
      end
    end
  end
endmodule

// File: tb/tb_key_entry_ctrl.sv
// tb_key_entry_ctrl: randomized and directed key sequences scored against a decimal model.
module tb_key_entry_ctrl;
  localparam int D = 4;
  localparam int K_PLUS = 16, K_MINUS = 17, K_BACKS = 18, K_ENTER = 19, K_UP = 20, K_DOWN = 21, K_NOP = 22;
  typedef struct {
    int          cyc;
    logic [15:0] entry;
    logic [2:0]  nd;
    logic [1:0]  stage;
    logic        valid;
    logic        drop;
  } st_t;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
  } op_t;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  key_value;
  logic        key_intro;
  logic        op_ready;
  logic [15:0] entry;
  logic [2:0]  ndigits;
  logic [1:0]  stage;
  logic        key_drop;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  st_t         exp_q[$];
  op_t         op_q[$];
  st_t         e;
  bit          hit;
  logic        probe = 1'b0;
  int          probe_kind = 0;
  int          m_val, m_nd, m_stage, m_a, m_b;
  bit          m_sub;
  key_entry_ctrl_if #(.DIGITS(4)) bus ();
  assign bus.op_ready = op_ready;
  key_entry_ctrl #(.DIGITS(4), .DEBOUNCE(D)) dut (
    .clk(clk), .rst_n(rst_n), .key_value(key_value), .key_intro(key_intro),
    .entry(entry), .ndigits(ndigits), .stage(stage), .key_drop(key_drop), .op(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  function automatic int ndig(input int v);
    int n = 0;
    while (v > 0) begin
      n++;
      v = v / 10;
    end
    return n;
  endfunction
  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp_v);
    end
  endfunction
  function automatic void clear_entry();
    m_stage = 0;
    m_val   = 0;
    m_nd    = 0;
  endfunction
  function automatic void push_state(input int c, input bit d);
    st_t s;
    s.cyc   = c;
    s.entry = to_bcd(m_val);
    s.nd    = 3'(m_nd);
    s.stage = 2'(m_stage);
    s.valid = (m_stage == 2);
    s.drop  = d;
    exp_q.push_back(s);
  endfunction
  // calculator behaviour in decimal terms: value, digit count, phase
  function automatic void model_key(input int code, output bit drop);
    op_t o;
    drop = 1'b0;
    if (m_stage == 2) drop = 1'b1;
    else if (code <= 9) begin
      if (m_nd == 4) drop = 1'b1;
      else if (!(code == 0 && m_nd == 0)) begin
        m_val = m_val * 10 + code;
        m_nd++;
      end
    end else if (code == K_BACKS) begin
      if (m_nd > 0) begin
        m_val = m_val / 10;
        m_nd--;
      end
    end else if (code == K_UP || code == K_DOWN) begin
      m_val = (code == K_UP) ? (m_val + 1) % 10000 : (m_val + 9999) % 10000;
      m_nd  = ndig(m_val);
    end else if (code == K_PLUS || code == K_MINUS) begin
      m_sub = (code == K_MINUS);
      if (m_stage == 0) begin
        m_a     = m_val;
        m_val   = 0;
        m_nd    = 0;
        m_stage = 1;
      end
    end else if (code == K_ENTER) begin
      if (m_stage == 0) drop = 1'b1;
      else begin
        m_b     = m_val;
        m_stage = 2;
        o.a     = to_bcd(m_a);
        o.b     = to_bcd(m_b);
        o.sub   = m_sub;
        op_q.push_back(o);
      end
    end
  endfunction
  task automatic press(input int code, input int hold);
    int t;
    bit d;
    t         = cyc;
    key_value = 5'(code);
    key_intro = 1'b1;
    if (hold >= D) begin
      model_key(code, d);
      push_state(t + 1 + D, d);
      if (op_ready && m_stage == 2) begin
        clear_entry();
        push_state(t + 2 + D, 1'b0);
      end
    end
    repeat (hold) @(posedge clk);
    #1;
    key_intro = 1'b0;
    key_value = 5'($urandom_range(0, 31));
    repeat (D + 2) @(posedge clk);
    #1;
  endtask
  task automatic keys(input int codes[$]);
    foreach (codes[i]) press(codes[i], D + 1);
  endtask
  task automatic release_op();
    int t;
    t        = cyc;
    op_ready = 1'b1;
    clear_entry();
    push_state(t + 1, 1'b0);
    @(posedge clk);
    #1;
    op_ready = 1'b0;
  endtask
  task automatic do_probe(input int kind);
    probe_kind = kind;
    probe      = 1'b1;
    #1;
    probe      = 1'b0;
  endtask
  always @(negedge clk or posedge probe) begin
    if (probe) begin
      if (probe_kind == 1) begin
        chk("rst_op_valid", 32'(bus.op_valid), 32'(0));
        chk("rst_entry", 32'(entry), 32'(0));
        chk("rst_ndigits", 32'(ndigits), 32'(0));
        chk("rst_stage", 32'(stage), 32'(0));
        chk("rst_op_a", 32'(bus.op_a), 32'(0));
        chk("rst_op_b", 32'(bus.op_b), 32'(0));
        chk("rst_op_sub", 32'(bus.op_sub), 32'(0));
        chk("rst_key_drop", 32'(key_drop), 32'(0));
      end else begin
        chk("exp_q_drained", 32'(exp_q.size()), 32'(0));
        chk("op_q_drained", 32'(op_q.size()), 32'(0));
      end
    end else if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("missed_update", 32'(cyc), 32'(exp_q[0].cyc));
        void'(exp_q.pop_front());
      end
      hit = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e   = exp_q.pop_front();
        hit = 1'b1;
        chk("entry", 32'(entry), 32'(e.entry));
        chk("ndigits", 32'(ndigits), 32'(e.nd));
        chk("stage", 32'(stage), 32'(e.stage));
        chk("op_valid", 32'(bus.op_valid), 32'(e.valid));
        chk("key_drop", 32'(key_drop), 32'(e.drop));
      end
      if (key_drop && !hit) chk("unexpected_drop", 32'(key_drop), 32'(0));
      if (bus.op_valid) begin
        if (op_q.size() == 0) chk("unexpected_op_valid", 32'(bus.op_valid), 32'(0));
        else begin
          chk("op_a", 32'(bus.op_a), 32'(op_q[0].a));
          chk("op_b", 32'(bus.op_b), 32'(op_q[0].b));
          chk("op_sub", 32'(bus.op_sub), 32'(op_q[0].sub));
          if (op_ready) void'(op_q.pop_front());
        end
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    int t;
    rst_n     = 1'b0;
    key_intro = 1'b0;
    key_value = 5'(K_NOP);
    op_ready  = 1'b0;
    clear_entry();
    m_a   = 0;
    m_b   = 0;
    m_sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_probe(1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    press(5, 20);
    press(K_BACKS, D);
    press(3, 3);
    press(3, 3);
    key_value = 5'd3;
    key_intro = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    press(7, D + 1);
    press(K_BACKS, D);
    keys('{0, 0, 1, 2, 3, 4, 5, K_BACKS});
    keys('{K_BACKS, K_BACKS, K_BACKS, 9, 9, 9, 9, K_UP, K_DOWN});
    keys('{K_BACKS, K_BACKS, K_BACKS, K_BACKS, 1, 0, 0, K_DOWN, K_BACKS, K_BACKS});
    keys('{1, 2, K_PLUS, K_MINUS, 7, K_ENTER});
    repeat (5) @(posedge clk);
    #1;
    press(4, D + 2);
    release_op();
    press(K_ENTER, D);
    keys('{3, K_PLUS, 4});
    op_ready = 1'b1;
    press(K_ENTER, D);
    op_ready = 1'b0;
    // key accepted on the very edge the ALU takes the request
    keys('{1, K_PLUS, 2, K_ENTER});
    t         = cyc;
    key_value = 5'd7;
    key_intro = 1'b1;
    clear_entry();
    push_state(t + 1 + D, 1'b1);
    repeat (D) @(posedge clk);
    #1;
    op_ready = 1'b1;
    @(posedge clk);
    #1;
    op_ready  = 1'b0;
    key_intro = 1'b0;
    repeat (D + 2) @(posedge clk);
    #1;
    keys('{6, K_PLUS, 2, K_ENTER});
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    do_probe(1);
    clear_entry();
    m_a   = 0;
    m_b   = 0;
    m_sub = 1'b0;
    op_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    key_value = 5'd6;
    key_intro = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    press(6, D + 1);
    for (int i = 0; i < 150; i++) begin
      int r, code, hold;
      if (m_stage == 2 && $urandom_range(0, 2) == 0) release_op();
      else begin
        r    = int'($urandom_range(0, 99));
        code = r < 45 ? int'($urandom_range(0, 9)) : r < 54 ? K_BACKS : r < 61 ? K_UP :
               r < 68 ? K_DOWN : r < 72 ? K_NOP : r < 75 ? 12 :
               r < 85 ? ($urandom_range(0, 1) ? K_PLUS : K_MINUS) : K_ENTER;
        hold = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, D - 1)) : int'($urandom_range(D, D + 4));
        if (m_stage != 2 && $urandom_range(0, 4) == 0) op_ready = 1'b1;
        press(code, hold);
        op_ready = 1'b0;
      end
    end
    if (m_stage == 2) release_op();
    repeat (D + 4) @(posedge clk);
    #1;
    do_probe(2);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
